alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals between two requesters, the arbiter and the ALU.
// slave: the arbiter's view. master: the environment's view (requesters plus ALU).
interface alu_arbiter_if #(
  parameter int unsigned NUMBITS = 16
) ();
  logic               req0_valid;
  logic               req0_ready;
  logic [2:0]         req0_opcode;
  logic [NUMBITS-1:0] req0_a;
  logic [NUMBITS-1:0] req0_b;

  logic               req1_valid;
  logic               req1_ready;
  logic [2:0]         req1_opcode;
  logic [NUMBITS-1:0] req1_a;
  logic [NUMBITS-1:0] req1_b;

  logic [2:0]         alu_opcode;
  logic [NUMBITS-1:0] alu_a;
  logic [NUMBITS-1:0] alu_b;
  logic [NUMBITS-1:0] alu_result;
  logic               alu_carryout;
  logic               alu_overflow;
  logic               alu_zero;

  logic               rsp0_valid;
  logic               rsp1_valid;
  logic [NUMBITS-1:0] rsp_result;
  logic               rsp_carryout;
  logic               rsp_overflow;
  logic               rsp_zero;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  alu_result, alu_carryout, alu_overflow, alu_zero,
    output req0_ready, req1_ready,
    output alu_opcode, alu_a, alu_b,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output alu_result, alu_carryout, alu_overflow, alu_zero,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_a, alu_b,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one registered ALU; one operation in flight,
// IDLE -> ISSUE -> WAIT -> RESP, response pulse three cycles after accept.
module alu_arbiter #(
  parameter int unsigned NUMBITS = 16
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic         busy,
  output logic [15:0]  done_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic               owner_q;
  logic               busy_q;
  logic               rsp0_valid_q;
  logic               rsp1_valid_q;
  logic [2:0]         alu_opcode_q;
  logic [NUMBITS-1:0] alu_a_q;
  logic [NUMBITS-1:0] alu_b_q;
  logic [NUMBITS-1:0] rsp_result_q;
  logic               rsp_carryout_q;
  logic               rsp_overflow_q;
  logic               rsp_zero_q;
  logic [15:0]        done_count_q;

  logic grant0;
  logic grant1;
  logic accept;
  logic winner;

  // Ready is gated by reset so nothing is granted while the block is held in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && (state_q == StIdle)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign accept = grant0 | grant1;
  assign winner = grant1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      busy_q         <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      alu_opcode_q   <= 3'd0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      rsp_result_q   <= '0;
      rsp_carryout_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
      done_count_q   <= 16'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q      <= StIssue;
            busy_q       <= 1'b1;
            last_grant_q <= winner;
            owner_q      <= winner;
            alu_opcode_q <= winner ? bus.req1_opcode : bus.req0_opcode;
            alu_a_q      <= winner ? bus.req1_a : bus.req0_a;
            alu_b_q      <= winner ? bus.req1_b : bus.req0_b;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          // ALU output now reflects the operands sampled at the end of ISSUE.
          state_q        <= StResp;
          rsp_result_q   <= bus.alu_result;
          rsp_carryout_q <= bus.alu_carryout;
          rsp_overflow_q <= bus.alu_overflow;
          rsp_zero_q     <= bus.alu_zero;
          rsp0_valid_q   <= ~owner_q;
          rsp1_valid_q   <= owner_q;
          // Counted on entry so the count already includes the response shown in RESP.
          done_count_q   <= done_count_q + 16'd1;
        end
        StResp: begin
          state_q      <= StIdle;
          busy_q       <= 1'b0;
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carryout = rsp_carryout_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign busy             = busy_q;
  assign done_count       = done_count_q;

endmodule
